gps_ack_peak: RTL and testbench

GPS_ACK_PEAK -- requirements
Module: gps_ack_peak

---
 rtl/gps_ack_peak.sv | 167 ++++++++++++++++
 tb/tb_gps_ack_peak.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_ack_peak.sv
// Per-lane peak search over a GPS code-phase sweep, four correlator lanes in parallel.
// Completed sweeps are queued as {prn, phase, peak, detect} entries in an 8-deep FIFO.
module gps_ack_peak #(
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              corr_complete,
   input  logic [9:0]        code_phase,
   input  logic [4:0]        sat0,
   input  logic [4:0]        sat1,
   input  logic [4:0]        sat2,
   input  logic [4:0]        sat3,
   input  logic [DATA_W-1:0] integrator_0,
   input  logic [DATA_W-1:0] integrator_1,
   input  logic [DATA_W-1:0] integrator_2,
   input  logic [DATA_W-1:0] integrator_3,
   input  logic [DATA_W-1:0] threshold,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_sat,
   output logic [9:0]        out_phase,
   output logic [DATA_W-1:0] out_peak,
   output logic              out_detect,
   output logic              overflow,
   output logic              sat_err
);
   localparam int DEPTH = 8;
   localparam int ENTRY_W = 5 + 10 + DATA_W + 1;
   localparam logic [9:0] FINAL_PHASE = 10'd1022;
   localparam logic [9:0] SKIP_PHASE = 10'd1023;

   logic              prev;
   logic              evt;
   logic [4:0]        sat_in [4];
   logic [DATA_W-1:0] mag_in [4];

   logic [3:0]        active;
   logic [4:0]        lat_sat [4];
   logic [DATA_W-1:0] peak [4];
   logic [9:0]        peak_phase [4];

   logic              phase_zero;
   logic              phase_run;
   logic              phase_final;
   logic [3:0]        mismatch;
   logic [3:0]        upd;
   logic [3:0]        emit;
   logic [DATA_W-1:0] cand_peak [4];
   logic [9:0]        cand_phase [4];
   logic [ENTRY_W-1:0] entry [4];
   logic [2:0]        offset [4];
   logic [2:0]        n_emit;

   logic [ENTRY_W-1:0] fifo_mem [DEPTH];
   logic [2:0]        wr_ptr;
   logic [2:0]        rd_ptr;
   logic [3:0]        count;
   logic              pop;
   logic [3:0]        free;
   logic              accept;
   logic              drop;
   logic [ENTRY_W-1:0] head;

   assign evt = corr_complete & ~prev;

   always_comb begin
      sat_in[0] = sat0;
      sat_in[1] = sat1;
      sat_in[2] = sat2;
      sat_in[3] = sat3;
      mag_in[0] = integrator_0;
      mag_in[1] = integrator_1;
      mag_in[2] = integrator_2;
      mag_in[3] = integrator_3;
   end

   // Lane decode: the running compare is folded in before the final-phase entry is formed.
   always_comb begin
      logic [2:0] n_acc;
      n_acc       = 3'd0;
      phase_zero  = (code_phase == 10'd0);
      phase_run   = (code_phase != 10'd0) && (code_phase != SKIP_PHASE);
      phase_final = (code_phase == FINAL_PHASE);
      mismatch    = '0;
      upd         = '0;
      emit        = '0;
      for (int i = 0; i < 4; i++) begin
         mismatch[i]   = evt & phase_run & active[i] & (sat_in[i] != lat_sat[i]);
         upd[i]        = evt & phase_run & active[i] & (sat_in[i] == lat_sat[i])
                         & (mag_in[i] > peak[i]);
         emit[i]       = evt & phase_final & active[i] & (sat_in[i] == lat_sat[i]);
         cand_peak[i]  = upd[i] ? mag_in[i] : peak[i];
         cand_phase[i] = upd[i] ? code_phase : peak_phase[i];
         entry[i]      = {lat_sat[i], cand_phase[i], cand_peak[i], (cand_peak[i] >= threshold)};
         offset[i]     = n_acc;
         n_acc         = n_acc + {2'b00, emit[i]};
      end
      n_emit = n_acc;
   end

   // Free slots count the same-cycle pop; a sweep is written whole or not at all.
   assign out_valid = (count != 4'd0);
   assign pop       = out_valid & out_ready;
   assign free      = 4'(DEPTH) - count + {3'b000, pop};
   assign accept    = (n_emit != 3'd0) && ({1'b0, n_emit} <= free);
   assign drop      = ({1'b0, n_emit} > free);

   always_ff @(posedge clk) begin
      if (rst) begin
         prev     <= 1'b0;
         active   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         sat_err  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            lat_sat[i]    <= '0;
            peak[i]       <= '0;
            peak_phase[i] <= '0;
         end
      end else begin
         prev <= corr_complete;
         for (int i = 0; i < 4; i++) begin
            if (evt && phase_zero) begin
               active[i]     <= 1'b1;
               lat_sat[i]    <= sat_in[i];
               peak[i]       <= mag_in[i];
               peak_phase[i] <= 10'd0;
            end else begin
               if (mismatch[i] || emit[i])
                  active[i] <= 1'b0;
               if (upd[i]) begin
                  peak[i]       <= mag_in[i];
                  peak_phase[i] <= code_phase;
               end
            end
         end
         if (|mismatch)
            sat_err <= 1'b1;
         if (drop)
            overflow <= 1'b1;
         if (accept)
            wr_ptr <= wr_ptr + n_emit;
         if (pop)
            rd_ptr <= rd_ptr + 3'd1;
         count <= count + (accept ? {1'b0, n_emit} : 4'd0) - {3'b000, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < 4; i++) begin
            if (emit[i])
               fifo_mem[wr_ptr + offset[i]] <= entry[i];
         end
      end
   end

   assign head       = fifo_mem[rd_ptr];
   assign out_sat    = out_valid ? head[ENTRY_W-1 -: 5] : '0;
   assign out_phase  = out_valid ? head[DATA_W+10 -: 10] : '0;
   assign out_peak   = out_valid ? head[DATA_W:1] : '0;
   assign out_detect = out_valid & head[0];

endmodule

// File: tb/tb_gps_ack_peak.sv
// Bench for gps_ack_peak: directed sweeps plus random sweeps, scoreboarded against a
// per-lane sample-history model (argmax with first occurrence) and a queue-size FIFO model.
module tb_gps_ack_peak;
   typedef struct {
      int sat;
      int ph;
      int pk;
      bit det;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        corr_complete;
   logic [9:0]  code_phase;
   logic [4:0]  sat_v [4];
   logic [11:0] mag_v [4];
   logic [11:0] threshold;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_sat;
   logic [9:0]  out_phase;
   logic [11:0] out_peak;
   logic        out_detect;
   logic        overflow;
   logic        sat_err;

   gps_ack_peak dut (
      .clk(clk), .rst(rst), .corr_complete(corr_complete), .code_phase(code_phase),
      .sat0(sat_v[0]), .sat1(sat_v[1]), .sat2(sat_v[2]), .sat3(sat_v[3]),
      .integrator_0(mag_v[0]), .integrator_1(mag_v[1]),
      .integrator_2(mag_v[2]), .integrator_3(mag_v[3]),
      .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
      .out_sat(out_sat), .out_phase(out_phase), .out_peak(out_peak),
      .out_detect(out_detect), .overflow(overflow), .sat_err(sat_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_fail = 0;
   ent_t sb[$];
   bit   exp_overflow, exp_sat_err, prev_m, rand_ready;
   bit   m_act [4];
   int   m_sat [4];
   int   m_n [4];
   int   m_ph [4][1024];
   int   m_val [4][1024];

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      exp_overflow = 0;
      exp_sat_err = 0;
      prev_m = 0;
      for (int i = 0; i < 4; i++) begin
         m_act[i] = 0;
         m_n[i] = 0;
      end
   endtask

   // Spec-level model: keep every sample of the sweep, pick the first maximum at the end.
   task automatic model_event();
      ent_t news[$];
      int ph;
      ph = int'(code_phase);
      if (ph == 1023) return;
      for (int i = 0; i < 4; i++) begin
         if (ph == 0) begin
            m_act[i] = 1;
            m_sat[i] = int'(sat_v[i]);
            m_n[i] = 0;
            m_ph[i][0] = 0;
            m_val[i][0] = int'(mag_v[i]);
            m_n[i] = 1;
         end else if (m_act[i]) begin
            if (int'(sat_v[i]) != m_sat[i]) begin
               m_act[i] = 0;
               exp_sat_err = 1;
            end else begin
               m_ph[i][m_n[i]] = ph;
               m_val[i][m_n[i]] = int'(mag_v[i]);
               m_n[i]++;
               if (ph == 1022) begin
                  ent_t e;
                  int best, bph;
                  best = -1;
                  bph = 0;
                  for (int k = 0; k < m_n[i]; k++)
                     if (m_val[i][k] > best) begin
                        best = m_val[i][k];
                        bph = m_ph[i][k];
                     end
                  e.sat = m_sat[i];
                  e.ph = bph;
                  e.pk = best;
                  e.det = (best >= int'(threshold));
                  news.push_back(e);
                  m_act[i] = 0;
               end
            end
         end
      end
      if (news.size() > 8 - sb.size())
         exp_overflow = 1;
      else
         foreach (news[k]) sb.push_back(news[k]);
   endtask

   task automatic tick();
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      if (rst) model_reset();
      else begin
         if (corr_complete && !prev_m) model_event();
         prev_m = corr_complete;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ev(input int ph, input int hold);
      code_phase = 10'(ph);
      corr_complete = 1'b1;
      for (int h = 0; h < hold; h++) tick();
      corr_complete = 1'b0;
      tick();
   endtask

   function automatic logic [11:0] rand_mag();
      if ($urandom_range(0, 3) == 0) return 12'($urandom_range(0, 3) * 1000);
      return 12'($urandom_range(0, 4095));
   endfunction

   task automatic rand_mags();
      for (int i = 0; i < 4; i++) mag_v[i] = rand_mag();
   endtask

   task automatic rand_sweep(input int nmid, input int hold, input bit pop_final, input bit wild);
      int p;
      logic [4:0] ss [4];
      p = 0;
      rand_mags();
      ev(0, hold);
      for (int m = 0; m < nmid; m++) begin
         p = p + int'($urandom_range(1, 150));
         if (p > 1021) p = 1021;
         rand_mags();
         if (wild && $urandom_range(0, 15) == 0) begin
            int l;
            l = int'($urandom_range(0, 3));
            sat_v[l] = sat_v[l] + 5'd1;
         end
         ev(p, hold);
         if (wild && $urandom_range(0, 7) == 0) begin
            ss = sat_v;
            for (int i = 0; i < 4; i++) sat_v[i] = 5'($urandom_range(0, 31));
            rand_mags();
            ev(1023, hold);
            sat_v = ss;
         end
      end
      rand_mags();
      if (pop_final) begin
         code_phase = 10'd1022;
         corr_complete = 1'b1;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         corr_complete = 1'b0;
         tick();
      end else ev(1022, hold);
   endtask

   task automatic drain();
      int budget;
      rand_ready = 0;
      out_ready = 1'b1;
      budget = 0;
      while (sb.size() > 0 && budget < 40) begin
         tick();
         budget++;
      end
      check("drain_timeout", sb.size(), 0);
      tick();
      out_ready = 1'b0;
   endtask

   task automatic set_sats(input int a, input int b, input int c, input int d);
      sat_v[0] = 5'(a); sat_v[1] = 5'(b); sat_v[2] = 5'(c); sat_v[3] = 5'(d);
   endtask

   task automatic short_main(input int hold);
      int phs [5] = '{0, 100, 417, 800, 1022};
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) mag_v[i] = 12'd100;
         if (phs[k] == 417) mag_v[0] = 12'd900;
         ev(phs[k], hold);
      end
   endtask

   // Monitor: compares handshake, flags and popped entries against the scoreboard.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("out_valid", int'(out_valid), int'(sb.size() != 0));
            check("overflow", int'(overflow), int'(exp_overflow));
            check("sat_err", int'(sat_err), int'(exp_sat_err));
            if (out_valid && out_ready && sb.size() > 0) begin
               e = sb.pop_front();
               check("out_sat", int'(out_sat), e.sat);
               check("out_phase", int'(out_phase), e.ph);
               check("out_peak", int'(out_peak), e.pk);
               check("out_detect", int'(out_detect), int'(e.det));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      corr_complete = 1'b0;
      code_phase = '0;
      threshold = 12'd500;
      out_ready = 1'b0;
      rand_ready = 0;
      set_sats(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) mag_v[i] = '0;
      model_reset();
      @(posedge clk);
      #1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_valid", int'(out_valid), 0);
      check("rst_sat", int'(out_sat), 0);
      check("rst_phase", int'(out_phase), 0);
      check("rst_peak", int'(out_peak), 0);
      check("rst_detect", int'(out_detect), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_sat_err", int'(sat_err), 0);

      // Full sweep, lane0 peaks at 417.
      set_sats(3, 7, 12, 31);
      for (int ph = 0; ph <= 1022; ph++) begin
         for (int i = 0; i < 4; i++) mag_v[i] = 12'd100;
         if (ph == 417) mag_v[0] = 12'd900;
         ev(ph, 1);
      end
      drain();

      // Tie on lane0 at phases 10 and 20.
      begin
         int phs [4] = '{0, 10, 20, 1022};
         for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) mag_v[i] = 12'd50;
            if (phs[k] == 10 || phs[k] == 20) mag_v[0] = 12'd600;
            ev(phs[k], 1);
         end
      end
      drain();

      // Strobe held for 5 cycles.
      short_main(5);
      drain();

      // Lane2 PRN changes mid-sweep.
      begin
         int phs [5] = '{0, 100, 500, 700, 1022};
         for (int k = 0; k < 5; k++) begin
            if (phs[k] == 500) sat_v[2] = 5'd13;
            rand_mags();
            ev(phs[k], 1);
         end
         set_sats(3, 7, 12, 31);
      end
      drain();

      // Three sweeps into a stalled FIFO, then a drop despite a same-cycle pop at 7 occupied.
      set_sats(1, 2, 4, 8);
      for (int s = 0; s < 3; s++) rand_sweep(3, 1, 0, 0);
      drain();
      rand_sweep(2, 1, 0, 0);
      rand_sweep(2, 1, 0, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      rand_sweep(2, 1, 1, 0);
      drain();

      // Reset with queued entries and a partial sweep, then a sweep starting right after rst.
      set_sats(5, 6, 7, 9);
      rand_sweep(2, 1, 0, 0);
      rand_mags();
      ev(0, 1);
      ev(300, 1);
      code_phase = 10'd600;
      corr_complete = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      code_phase = 10'd0;
      rand_mags();
      tick();
      corr_complete = 1'b0;
      tick();
      set_sats(20, 21, 22, 23);
      for (int i = 0; i < 4; i++) mag_v[i] = 12'd4095;
      ev(1023, 1);
      set_sats(5, 6, 7, 9);
      for (int i = 0; i < 4; i++) mag_v[i] = 12'd4000;
      ev(1023, 2);
      rand_mags();
      ev(512, 1);
      rand_mags();
      ev(1022, 1);
      drain();

      // Random sweeps with random back-pressure, PRN changes and skip-phase events.
      rand_ready = 1;
      for (int s = 0; s < 30; s++) begin
         for (int i = 0; i < 4; i++) sat_v[i] = 5'($urandom_range(0, 31));
         threshold = 12'($urandom_range(0, 4095));
         rand_sweep(int'($urandom_range(0, 6)), int'($urandom_range(1, 3)), 0, 1);
         repeat ($urandom_range(0, 3)) tick();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
